// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder datapath.
package adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// 1-bit full-adder cell: sum and carry of a, b and carry-in c.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder, LSB first, one full-adder cell plus a carry flop.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_sum, fa_carry;

   serial_adder_fa u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // Next-state and datapath updates; done is a pulse, everything else holds by default.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sr_d  = a_in;
               b_sr_d  = b_in;
               carry_d = cin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_d  = {fa_sum, s_sr_q[WIDTH-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
               cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d   = carry_q ^ fa_carry;
`endif
               cnt_d   = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign sum_out = sum_q;
   assign cout    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf     = ovf_q;
`else
   assign ovf     = 1'b0;
`endif

endmodule
